// File: rtl/seven_seg_scan_if.sv
// Display-side bus for seven_seg_scan: packed BCD/enables in, anode/cathode drive out.
interface seven_seg_scan_if;
    logic [31:0] time_display;
    logic [7:0]  digit_enable;
    logic [7:0]  dp_enable;
    logic [7:0]  anode_n;
    logic [6:0]  cathode_n;
    logic        dp_n;

    modport master (
        output time_display, digit_enable, dp_enable,
        input  anode_n, cathode_n, dp_n
    );

    modport slave (
        input  time_display, digit_enable, dp_enable,
        output anode_n, cathode_n, dp_n
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Frame-coherent 8-digit multiplexed seven-segment driver with per-slot blanking.
// Optional macro SEG_HEX_EN renders nibbles 10-15 as A,b,C,d,E,F instead of a dash.
module seven_seg_scan #(
    parameter int unsigned FREQ_HZ      = 100000000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    seven_seg_scan_if.slave    bus
);

    localparam int unsigned DwellRaw = FREQ_HZ / (REFRESH_HZ * 8);
    localparam int unsigned Dwell    = (DwellRaw < BLANK_CYCLES + 1) ? BLANK_CYCLES + 1
                                                                     : DwellRaw;
    localparam int unsigned CntW     = (Dwell > 1) ? $clog2(Dwell) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(Dwell - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

    typedef enum logic {StBlank, StShow} phase_e;

    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     val_s_q;
    logic [7:0]      en_s_q, dp_s_q;
    logic            snap_load;

    logic [7:0] an_q, an_d;
    logic [6:0] cat_q, cat_d;
    logic       dp_q, dp_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
`ifdef SEG_HEX_EN
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
`else
            default: seg = 7'h3F;
`endif
        endcase
        return seg;
    endfunction

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_q == CntLast) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        phase_d   = (cnt_d >= CntBlank) ? StShow : StBlank;
        snap_load = (idx_q == 3'd0) && (cnt_q == '0) && (phase_q == StBlank);

        // Outputs are a registered image of the current slot state.
        an_d  = 8'hFF;
        cat_d = 7'h7F;
        dp_d  = 1'b1;
        if (phase_q == StShow) begin
            if (en_s_q[idx_q]) an_d = ~(8'b1 << idx_q);
            cat_d = seg_decode(val_s_q[{idx_q, 2'b00} +: 4]);
            dp_d  = ~(dp_s_q[idx_q] & en_s_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            val_s_q <= '0;
            en_s_q  <= '0;
            dp_s_q  <= '0;
            an_q    <= 8'hFF;
            cat_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            cat_q   <= cat_d;
            dp_q    <= dp_d;
            if (snap_load) begin
                val_s_q <= bus.time_display;
                en_s_q  <= bus.digit_enable;
                dp_s_q  <= bus.dp_enable;
            end
        end
    end

    assign bus.anode_n   = an_q;
    assign bus.cathode_n = cat_q;
    assign bus.dp_n      = dp_q;

endmodule
